// File: rtl/apb_uart_regs.sv
// APB3 register front-end for the UART core: TX holding register, RX pop, prescale,
// interrupt enables, sticky error flags and a registered level interrupt.
module apb_uart_regs #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd54
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_out,
  output logic [15:0]           prescale,
  output logic                  irq
);

  localparam logic [2:0] RegData     = 3'd0;
  localparam logic [2:0] RegStatus   = 3'd1;
  localparam logic [2:0] RegPrescale = 3'd2;
  localparam logic [2:0] RegIrqEn    = 3'd3;

  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [2:0]            irq_en_q, irq_en_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic                  rx_unf_q, rx_unf_d;
  logic                  irq_q, irq_d;

  logic       access;
  logic [2:0] reg_sel;
  logic       bad_addr;
  logic       data_wr, data_rd, status_wr, prescale_wr, irq_en_wr;
  logic       tx_pop, tx_free, tx_accept, tx_ovf_set, rx_unf_set;
  logic [31:0] status_val;

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  always_comb begin
    access      = psel & penable;
    reg_sel     = paddr[4:2];
    bad_addr    = reg_sel[2];
    data_wr     = access & pwrite & (reg_sel == RegData);
    data_rd     = access & ~pwrite & (reg_sel == RegData);
    status_wr   = access & pwrite & (reg_sel == RegStatus);
    prescale_wr = access & pwrite & (reg_sel == RegPrescale);
    irq_en_wr   = access & pwrite & (reg_sel == RegIrqEn);

    // The holding register counts as free when it drains on this same edge.
    tx_pop     = tx_valid_q & tx_ready_in;
    tx_free    = ~tx_valid_q | tx_ready_in;
    tx_accept  = data_wr & tx_free;
    tx_ovf_set = data_wr & ~tx_free;
    rx_unf_set = data_rd & ~rx_valid_in;

    status_val = {28'd0, rx_unf_q, tx_ovf_q, rx_valid_in, ~tx_valid_q};
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = pwdata[DATA_WIDTH-1:0];
    end else if (tx_pop) begin
      tx_valid_d = 1'b0;
    end

    prescale_d = prescale_wr ? pwdata[15:0] : prescale_q;
    irq_en_d   = irq_en_wr ? pwdata[2:0] : irq_en_q;

    // Set beats a simultaneous write-1-to-clear.
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(status_wr & pwdata[2]));
    rx_unf_d = rx_unf_set | (rx_unf_q & ~(status_wr & pwdata[3]));

    irq_d = (irq_en_q[0] & rx_valid_in) |
            (irq_en_q[1] & ~tx_valid_q) |
            (irq_en_q[2] & (tx_ovf_q | rx_unf_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      prescale_q <= DEFAULT_PRESCALE;
      irq_en_q   <= 3'b000;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      prescale_q <= prescale_d;
      irq_en_q   <= irq_en_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_unf_q   <= rx_unf_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite) begin
      case (reg_sel)
        RegData:     prdata = rx_valid_in ? {{(32-DATA_WIDTH){1'b0}}, rx_data_in} : 32'd0;
        RegStatus:   prdata = status_val;
        RegPrescale: prdata = {16'd0, prescale_q};
        RegIrqEn:    prdata = {29'd0, irq_en_q};
        default:     prdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    pready       = access;
    pslverr      = access & (bad_addr | tx_ovf_set | rx_unf_set);
    // Pop is suppressed during reset so no RX byte is lost.
    rx_ready_out = data_rd & rx_valid_in & ~rst;
    tx_valid_out = tx_valid_q;
    tx_data_out  = tx_data_q;
    prescale     = prescale_q;
    irq          = irq_q;
  end

endmodule

// File: doc/apb_uart_regs.md
Name: apb_uart_regs

Overview:
- APB3 slave register front-end for the UART core: turns CPU bus accesses into the byte-stream handshakes of uart_fifo and drives its prescale input.
- Downstream, it feeds the TX stream and consumes the RX stream.
- Contains a one-entry TX holding register, the prescale/control registers, sticky error flags and a registered interrupt output.

Parameters:
- DATA_WIDTH, 8, UART byte width; must match uart_fifo.
- ADDR_WIDTH, 5, APB address width; register select uses paddr[4:2].
- DEFAULT_PRESCALE, 16'd54, prescale reset value (50 MHz clock, 115200 baud).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write (1) / read (0).
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- tx_data_out  out  DATA_WIDTH  to uart_fifo tx_data_in.
- tx_valid_out  out  1  to uart_fifo tx_valid_in.
- tx_ready_in  in  1  from uart_fifo tx_ready_out.
- rx_data_in  in  DATA_WIDTH  from uart_fifo rx_data_out.
- rx_valid_in  in  1  from uart_fifo rx_valid_out.
- rx_ready_out  out  1  to uart_fifo rx_ready_in.
- prescale  out  16  to uart_fifo prescale.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: tx_valid_out=0, tx_data_out=0, prescale=DEFAULT_PRESCALE, IRQ_EN=0, sticky flags=0, irq=0.
- APB protocol:
  - Zero wait states: pready = psel & penable.
  - An access takes effect only on the edge where psel & penable = 1.
  - Setup phase (psel=1, penable=0) has no side effects.
- Register map, selected by paddr[4:2]:
  - 0x00 DATA: W pushes a byte; R pops a byte.
  - 0x04 STATUS, R/W1C:
    - [0] tx_ready = ~tx_valid_out
    - [1] rx_valid = rx_valid_in
    - [2] tx_overflow, sticky
    - [3] rx_underflow, sticky
  - 0x08 PRESCALE, RW: [15:0].
  - 0x0C IRQ_EN, RW:
    - [0] rx_valid
    - [1] tx_ready
    - [2] error
  - Unused upper bits read 0.
  - Addresses 0x10–0x1C: reads return 0, writes are ignored, pslverr=1.
- TX holding register:
  - A DATA write is accepted if the holding register is free pre-edge, i.e. tx_valid_out=0, or tx_valid_out & tx_ready_in in the same cycle.
  - On accept: tx_data_out <= pwdata[DATA_WIDTH-1:0] and tx_valid_out <= 1.
  - If the register is occupied and not being accepted: data is dropped, tx_overflow <= 1, pslverr=1.
  - tx_valid_out drops on the edge where tx_valid_out & tx_ready_in, unless it is reloaded by a same-cycle write.
  - tx_data_out is stable while tx_valid_out=1.
- RX read:
  - rx_ready_out = psel & penable & ~pwrite & (DATA addr) & rx_valid_in. This is combinational and asserted for exactly one cycle per read.
  - prdata = {0, rx_data_in} in that cycle, and the byte is popped at that edge.
  - A DATA read with rx_valid_in=0 returns prdata=0, sets rx_underflow <= 1 and asserts pslverr=1.
- prdata:
  - Combinational register mux, valid when psel & ~pwrite.
  - 0 otherwise.
- Sticky flags:
  - Writing 1 to STATUS[2] or STATUS[3] clears that flag.
  - If a set event and a W1C occur on the same edge, set wins.
- PRESCALE:
  - A write updates the prescale output on the next edge.
  - A byte in flight is not affected by this block; retiming is the core's responsibility.
- irq (registered, one-cycle latency from its causes): irq <= (en[0] & rx_valid_in) | (en[1] & ~tx_valid_out) | (en[2] & (tx_overflow | rx_underflow)).
- Reset mid-operation: a pending TX byte is discarded (tx_valid_out=0 on the edge after rst), all registers return to reset values, and no pop occurs while rst=1. Bus outputs are don't-care during rst.

Test Plan:
1. Reset:
   - Stimulus: assert rst, then read STATUS and PRESCALE.
   - Required: STATUS=0x1, PRESCALE=54, irq=0, tx_valid_out=0.
2. TX write:
   - Stimulus: write DATA=0x48 with tx_ready_in=0 held for 5 cycles, then tx_ready_in=1.
   - Required: tx_data_out=0x48, tx_valid_out=1 until the handshake edge, then 0; STATUS[0] reads 0 while pending.
3. TX overflow:
   - Stimulus: write 0x45 then 0x4C while tx_ready_in=0.
   - Required: second write gets pslverr=1, tx_data_out stays 0x45, STATUS[2]=1. Writing STATUS=0x4 clears it.
4. TX same-cycle accept:
   - Stimulus: with 0x4C pending, write 0x4F in the same cycle tx_ready_in=1.
   - Required: no overflow, tx_data_out=0x4F, tx_valid_out stays 1.
5. RX pop:
   - Stimulus: rx_valid_in=1, rx_data_in=0x4F, then read DATA.
   - Required: prdata=0x4F, rx_ready_out high for exactly 1 cycle. Reading with rx_valid_in=0 returns 0, pslverr=1, STATUS[3]=1.
6. IRQ and PRESCALE:
   - Stimulus: IRQ_EN=0x1 and raise rx_valid_in.
   - Required: irq rises 1 cycle later. Writing PRESCALE=0x1B2 gives prescale=0x01B2 next cycle; reading 0x10 gives pslverr=1, prdata=0.
